// File: rtl/or1k_branch_predictor_ctrl_if.sv
// Decode/execute-side signal bundle for the OR1K branch-prediction controller.
// The pipeline drives the master side and the predictor sits on the slave side.
interface or1k_branch_predictor_ctrl_if #(
  parameter int OPTION_OPERAND_WIDTH = 32
);
  // Handshake: padv_decode_i / padv_execute_i act as one-cycle "advance" strobes.
  // A transfer happens on a rising clock edge where the strobe is high. There is
  // no back-pressure, and the predictor always accepts. pipeline_flush_i overrides
  // both strobes for capture and resolution.
  logic                            padv_decode_i;
  logic [OPTION_OPERAND_WIDTH-1:0] decode_pc_i;
  logic                            decode_op_bf_i;
  logic                            decode_op_bnf_i;
  logic [9:0]                      decode_immjbr_upper_i;
  logic                            predicted_flag_o;
  logic                            padv_execute_i;
  logic                            execute_flag_i;
  logic                            pipeline_flush_i;
  logic                            mispredict_o;
  logic [31:0]                     bp_branch_cnt_o;
  logic [31:0]                     bp_miss_cnt_o;

  modport master (
    output padv_decode_i, decode_pc_i, decode_op_bf_i, decode_op_bnf_i,
           decode_immjbr_upper_i, padv_execute_i, execute_flag_i, pipeline_flush_i,
    input  predicted_flag_o, mispredict_o, bp_branch_cnt_o, bp_miss_cnt_o
  );

  modport slave (
    input  padv_decode_i, decode_pc_i, decode_op_bf_i, decode_op_bnf_i,
           decode_immjbr_upper_i, padv_execute_i, execute_flag_i, pipeline_flush_i,
    output predicted_flag_o, mispredict_o, bp_branch_cnt_o, bp_miss_cnt_o
  );
endinterface

// File: rtl/or1k_branch_predictor_ctrl.sv
// OR1K dynamic branch predictor: 2-bit-counter BHT with a static BTFN fallback for untrained entries.
// Optional statistics counters are built when OR1K_BRANCH_PREDICTOR_STATS_EN is defined.
module or1k_branch_predictor_ctrl #(
  parameter int BHT_IDX_WIDTH        = 2,
  parameter int OPTION_OPERAND_WIDTH = 32
) (
  input logic                         clk,
  input logic                         rst_n,
  or1k_branch_predictor_ctrl_if.slave bp
);
  localparam int N = 1 << BHT_IDX_WIDTH;

  logic [1:0]               ctr_q [N];
  logic [N-1:0]             trained_q;
  logic                     ex_valid_q, ex_valid_d;
  logic [BHT_IDX_WIDTH-1:0] ex_idx_q, ex_idx_d;
  logic                     ex_pred_flag_q, ex_pred_flag_d;
  logic                     ex_is_bf_q, ex_is_bf_d;

  logic [BHT_IDX_WIDTH-1:0] dec_idx;
  logic                     is_branch, dec_taken, pred_flag;
  logic                     capture, resolve, actual_taken;
  logic [1:0]               cur_ctr, train_ctr;
  logic                     unused_bits;

  assign unused_bits = ^{bp.decode_pc_i[OPTION_OPERAND_WIDTH-1:BHT_IDX_WIDTH+2],
                         bp.decode_pc_i[1:0], bp.decode_immjbr_upper_i[8:0]};

  assign dec_idx   = bp.decode_pc_i[BHT_IDX_WIDTH+1:2];
  assign is_branch = bp.decode_op_bf_i | bp.decode_op_bnf_i;
  // Decode reads the registered table, so training in the same cycle is not bypassed.
  assign dec_taken = trained_q[dec_idx] ? ctr_q[dec_idx][1] : bp.decode_immjbr_upper_i[9];
  assign pred_flag = (bp.decode_op_bf_i & dec_taken) | (bp.decode_op_bnf_i & ~dec_taken);
  assign bp.predicted_flag_o = pred_flag;

  assign capture      = bp.padv_decode_i & is_branch & ~bp.pipeline_flush_i;
  assign resolve      = bp.padv_execute_i & ex_valid_q & ~bp.pipeline_flush_i;
  assign bp.mispredict_o = resolve & (bp.execute_flag_i != ex_pred_flag_q);
  assign actual_taken = ex_is_bf_q ? bp.execute_flag_i : ~bp.execute_flag_i;

  always_comb begin
    cur_ctr   = ctr_q[ex_idx_q];
    train_ctr = cur_ctr;
    if (!trained_q[ex_idx_q]) begin
      // First training jumps straight to the weak state matching the outcome.
      train_ctr = actual_taken ? 2'b10 : 2'b01;
    end else if (actual_taken) begin
      if (cur_ctr != 2'b11) train_ctr = cur_ctr + 2'd1;
    end else begin
      if (cur_ctr != 2'b00) train_ctr = cur_ctr - 2'd1;
    end
  end

  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_idx_d       = ex_idx_q;
    ex_pred_flag_d = ex_pred_flag_q;
    ex_is_bf_d     = ex_is_bf_q;
    if (capture) begin
      ex_valid_d     = 1'b1;
      ex_idx_d       = dec_idx;
      ex_pred_flag_d = pred_flag;
      ex_is_bf_d     = bp.decode_op_bf_i;
    end else if (bp.padv_execute_i | bp.pipeline_flush_i) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q     <= 1'b0;
      ex_idx_q       <= '0;
      ex_pred_flag_q <= 1'b0;
      ex_is_bf_q     <= 1'b0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_idx_q       <= ex_idx_d;
      ex_pred_flag_q <= ex_pred_flag_d;
      ex_is_bf_q     <= ex_is_bf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) ctr_q[i] <= 2'b01;
      trained_q <= '0;
    end else if (resolve) begin
      ctr_q[ex_idx_q]     <= train_ctr;
      trained_q[ex_idx_q] <= 1'b1;
    end
  end

`ifdef OR1K_BRANCH_PREDICTOR_STATS_EN
  logic [31:0] branch_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (resolve)          branch_cnt_q <= branch_cnt_q + 32'd1;
      if (bp.mispredict_o)  miss_cnt_q   <= miss_cnt_q + 32'd1;
    end
  end

  assign bp.bp_branch_cnt_o = branch_cnt_q;
  assign bp.bp_miss_cnt_o   = miss_cnt_q;
`else
  assign bp.bp_branch_cnt_o = 32'd0;
  assign bp.bp_miss_cnt_o   = 32'd0;
`endif
endmodule

// File: tb/tb_or1k_branch_predictor_ctrl.sv
// Bench for or1k_branch_predictor_ctrl: directed test-plan sequences plus random traffic,
// scored against a behavioural model of the BHT, the in-flight branch and the statistics.
module tb_or1k_branch_predictor_ctrl;
  logic clk;
  logic rst_n;

  or1k_branch_predictor_ctrl_if #(.OPTION_OPERAND_WIDTH(32)) bp ();

  or1k_branch_predictor_ctrl #(.BHT_IDX_WIDTH(2), .OPTION_OPERAND_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state: {predicted_flag, mispredict, branch_cnt, miss_cnt}
  logic [65:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // behavioural reference model
  int          m_ctr[4];
  bit          m_trained[4];
  bit          m_ex_valid;
  int          m_ex_idx;
  bit          m_ex_pred;
  bit          m_ex_bf;
  logic [31:0] m_bcnt;
  logic [31:0] m_mcnt;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_ctr[i]     = 1;
      m_trained[i] = 0;
    end
    m_ex_valid = 0;
    m_ex_idx   = 0;
    m_ex_pred  = 0;
    m_ex_bf    = 0;
    m_bcnt     = 0;
    m_mcnt     = 0;
  endtask

  // Drives one cycle of inputs, pushes the expected outputs, then advances the model past the edge.
  task automatic cyc(input bit rst, input bit dec, input logic [31:0] pc, input bit bf,
                     input bit bnf, input logic [9:0] up, input bit exe, input bit flag,
                     input bit flush);
    int idx;
    bit taken, pred, res, misp, actual;
    logic [31:0] e_b, e_m;
    @(negedge clk);
    #1;
    rst_n                    = !rst;
    bp.padv_decode_i         = dec;
    bp.decode_pc_i           = pc;
    bp.decode_op_bf_i        = bf;
    bp.decode_op_bnf_i       = bnf;
    bp.decode_immjbr_upper_i = up;
    bp.padv_execute_i        = exe;
    bp.execute_flag_i        = flag;
    bp.pipeline_flush_i      = flush;
    if (rst) model_reset();
    idx   = int'(pc[3:2]);
    taken = m_trained[idx] ? (m_ctr[idx] >= 2) : up[9];
    pred  = (bf && taken) || (bnf && !taken);
    res   = !rst && exe && m_ex_valid && !flush;
    misp  = res && (flag != m_ex_pred);
`ifdef OR1K_BRANCH_PREDICTOR_STATS_EN
    e_b = m_bcnt;
    e_m = m_mcnt;
`else
    e_b = 32'd0;
    e_m = 32'd0;
`endif
    exp_q.push_back({pred, misp, e_b, e_m});
    if (!rst) begin
      if (res) begin
        actual = m_ex_bf ? flag : !flag;
        if (!m_trained[m_ex_idx]) begin
          m_ctr[m_ex_idx]     = actual ? 2 : 1;
          m_trained[m_ex_idx] = 1;
        end else if (actual) begin
          m_ctr[m_ex_idx] = (m_ctr[m_ex_idx] == 3) ? 3 : m_ctr[m_ex_idx] + 1;
        end else begin
          m_ctr[m_ex_idx] = (m_ctr[m_ex_idx] == 0) ? 0 : m_ctr[m_ex_idx] - 1;
        end
        m_bcnt = m_bcnt + 32'd1;
        if (misp) m_mcnt = m_mcnt + 32'd1;
      end
      if (dec && (bf || bnf) && !flush) begin
        m_ex_valid = 1;
        m_ex_idx   = idx;
        m_ex_pred  = pred;
        m_ex_bf    = bf;
      end else if (exe || flush) begin
        m_ex_valid = 0;
      end
    end
  endtask

  // driver tasks
  task automatic idle();
    cyc(0, 0, 32'h0, 0, 0, 10'h0, 0, 0, 0);
  endtask

  task automatic probe(input logic [31:0] pc, input bit bf, input logic [9:0] up);
    cyc(0, 0, pc, bf, !bf, up, 0, 0, 0);
  endtask

  task automatic branch(input logic [31:0] pc, input bit bf, input logic [9:0] up, input bit flag);
    cyc(0, 1, pc, bf, !bf, up, 0, 0, 0);
    cyc(0, 0, 32'h0, 0, 0, 10'h0, 1, flag, 0);
  endtask

  // monitor: compares DUT outputs with the oldest expectation, away from the active edge
  always @(negedge clk) begin
    #3;
    if (exp_q.size() != 0) begin
      logic [65:0] e;
      e = exp_q.pop_front();
      checks++;
      if (bp.predicted_flag_o !== e[65]) begin
        errors++;
        $display("FAIL predicted_flag t=%0t got %b exp %b", $time, bp.predicted_flag_o, e[65]);
      end
      checks++;
      if (bp.mispredict_o !== e[64]) begin
        errors++;
        $display("FAIL mispredict t=%0t got %b exp %b", $time, bp.mispredict_o, e[64]);
      end
      checks++;
      if (bp.bp_branch_cnt_o !== e[63:32]) begin
        errors++;
        $display("FAIL branch_cnt t=%0t got %0d exp %0d", $time, bp.bp_branch_cnt_o, e[63:32]);
      end
      checks++;
      if (bp.bp_miss_cnt_o !== e[31:0]) begin
        errors++;
        $display("FAIL miss_cnt t=%0t got %0d exp %0d", $time, bp.bp_miss_cnt_o, e[31:0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bp.padv_decode_i = 0; bp.decode_pc_i = 0; bp.decode_op_bf_i = 0; bp.decode_op_bnf_i = 0;
    bp.decode_immjbr_upper_i = 0; bp.padv_execute_i = 0; bp.execute_flag_i = 0;
    bp.pipeline_flush_i = 0;
    model_reset();

    // reset state
    cyc(1, 0, 32'h0, 0, 0, 10'h0, 0, 0, 0);
    cyc(1, 0, 32'h0, 0, 0, 10'h0, 0, 0, 0);
    idle();

    // static rule on untrained entries
    probe(32'h0, 1, 10'h200);
    probe(32'h0, 1, 10'h000);
    probe(32'h0, 0, 10'h200);
    probe(32'h0, 0, 10'h000);

    // backward l.bf resolved not-taken: mispredict, then trained weakly not-taken
    branch(32'h10, 1, 10'h200, 0);
    probe(32'h10, 1, 10'h200);

    // saturation and hysteresis on one entry
    for (int i = 0; i < 4; i++) branch(32'h14, 1, 10'h000, 1);
    branch(32'h14, 1, 10'h000, 0);
    probe(32'h14, 1, 10'h000);
    branch(32'h14, 1, 10'h000, 0);
    probe(32'h14, 1, 10'h000);

    // flush before resolution, then flush concurrent with decode
    cyc(0, 1, 32'h18, 1, 0, 10'h200, 0, 0, 0);
    cyc(0, 0, 32'h0, 0, 0, 10'h0, 0, 0, 1);
    cyc(0, 0, 32'h0, 0, 0, 10'h0, 1, 0, 0);
    probe(32'h18, 1, 10'h200);
    cyc(0, 1, 32'h18, 1, 0, 10'h200, 0, 0, 1);
    cyc(0, 0, 32'h0, 0, 0, 10'h0, 1, 0, 0);

    // decode reads the old counter during training of the same entry
    branch(32'h20, 1, 10'h000, 1);
    cyc(0, 1, 32'h20, 1, 0, 10'h000, 0, 0, 0);
    cyc(0, 0, 32'h20, 1, 0, 10'h000, 1, 0, 0);
    probe(32'h20, 1, 10'h000);

    // back-to-back capture while resolving the previous branch
    cyc(0, 1, 32'h24, 0, 1, 10'h200, 0, 0, 0);
    cyc(0, 1, 32'h28, 1, 0, 10'h200, 1, 1, 0);
    cyc(0, 0, 32'h0, 0, 0, 10'h0, 1, 0, 0);

    // reset mid-sequence with a branch in flight
    cyc(0, 1, 32'h10, 1, 0, 10'h000, 0, 0, 0);
    cyc(1, 0, 32'h10, 1, 0, 10'h000, 0, 0, 0);
    cyc(0, 0, 32'h10, 1, 0, 10'h000, 1, 1, 0);
    probe(32'h10, 1, 10'h000);

    // ten resolutions, three of them mispredicted
    for (int i = 0; i < 10; i++) branch(32'h30, 1, 10'h200, (i % 3 == 2) ? 1'b0 : 1'b1);
    idle();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int sel;
      sel = $urandom_range(0, 2);
      cyc($urandom_range(0, 399) == 0, $urandom_range(0, 3) != 0, $urandom() & 32'hFFFF_FFFC,
          sel == 1, sel == 2, 10'($urandom_range(0, 1023)), $urandom_range(0, 2) != 0,
          1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    end

    // final report
    repeat (3) @(negedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
